// File: rtl/jk_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// jk_load_ctrl_if
//
// Purpose:
//    Bundles the signals between jk_load_ctrl and the two parties it serves.
//    One party is the register-write requester, which uses start, target,
//    busy, done and err. The other is the jkff bank, which uses q_fb, j and k.
//
// Signals:
//    start   requester -> ctrl  request pulse, sampled while the controller idles
//    target  requester -> ctrl  desired bank word, captured with start
//    q_fb    bank      -> ctrl  current q outputs of the jkff bank
//    j       ctrl      -> bank  registered J excitation
//    k       ctrl      -> bank  registered K excitation
//    busy    ctrl      -> req   high while a load is in flight
//    done    ctrl      -> req   one-cycle pulse, load verified
//    err     ctrl      -> req   one-cycle pulse, retries exhausted
//
// Modports:
//    master  the environment: requester plus bank
//    slave   the controller
// -----------------------------------------------------------------------------
interface jk_load_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] q_fb;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start,
      output target,
      output q_fb,
      input  j,
      input  k,
      input  busy,
      input  done,
      input  err
   );

   modport slave (
      input  start,
      input  target,
      input  q_fb,
      output j,
      output k,
      output busy,
      output done,
      output err
   );
endinterface

// File: rtl/jk_load_ctrl.sv
// -----------------------------------------------------------------------------
// jk_load_ctrl
//
// Purpose:
//    Loads a target word into a WIDTH-bit bank of JK flip-flops.
//    The controller works out a per-bit J/K excitation from the bank's q
//    feedback and applies it for exactly one cycle. It then reads the bank
//    back and compares it with the target. On a mismatch it drives again,
//    up to MAX_RETRY extra times, and then reports err.
//
// Ports:
//    clk    single clock, all state changes on the rising edge
//    rst    asynchronous, active-low reset
//    bus    jk_load_ctrl_if.slave
//           start/target/busy/done/err connect to the requester.
//           q_fb/j/k connect to the jkff bank.
//
// Parameters:
//    WIDTH      number of flip-flops in the bank
//    MAX_RETRY  extra drive attempts after the first failed check (0..15)
//
// Build option:
//    JK_LOAD_TOGGLE_EN  when defined, DRIVE uses toggle excitation
//                       (j = k = tgt ^ q). By default DRIVE uses set/reset
//                       excitation (j = tgt & ~q, k = ~tgt & q), so no bit
//                       ever sees j and k high together.
//
// Timing for a clean load:
//    start is sampled at edge N. j/k are valid in cycle N+1 (DRIVE).
//    The compare happens in cycle N+2 (CHECK). done is high in cycle N+3.
// -----------------------------------------------------------------------------
module jk_load_ctrl #(
   parameter int WIDTH     = 8,
   parameter int MAX_RETRY = 3
) (
   input logic           clk,
   input logic           rst,
   jk_load_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   // The retry counter is 4 bits wide. It only increments while it is
   // below this limit, so it stops at the limit and never wraps.
   localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] tgt_reg;
   logic [WIDTH-1:0] tgt_next;
   logic [3:0]       retry_reg;
   logic [3:0]       retry_next;
   logic [WIDTH-1:0] j_reg;
   logic [WIDTH-1:0] j_next;
   logic [WIDTH-1:0] k_reg;
   logic [WIDTH-1:0] k_next;

   // j/k are registered, so the excitation is computed one cycle ahead,
   // in whichever state leads into DRIVE.
   // - From IDLE, the target has not been captured yet, so the live
   //   request word is used.
   // - From CHECK (a retry), the captured word is used.
   logic [WIDTH-1:0] exc_tgt;
   logic [WIDTH-1:0] j_exc;
   logic [WIDTH-1:0] k_exc;

   assign exc_tgt = (state_reg == ST_IDLE) ? bus.target : tgt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_exc
`ifdef JK_LOAD_TOGGLE_EN
         // A wrong bit gets j=k=1, so the flip-flop toggles it.
         // A correct bit gets j=k=0, so it holds.
         assign j_exc[gi] = exc_tgt[gi] ^ bus.q_fb[gi];
         assign k_exc[gi] = exc_tgt[gi] ^ bus.q_fb[gi];
`else
         // Set only the bits that must rise and reset only the bits that
         // must fall. Correct bits get j=k=0 (hold). j and k are never
         // both high.
         assign j_exc[gi] = exc_tgt[gi] & ~bus.q_fb[gi];
         assign k_exc[gi] = ~exc_tgt[gi] & bus.q_fb[gi];
`endif
      end
   endgenerate

   // State register. Reset is asynchronous, so an in-flight load is
   // abandoned at once and no done/err pulse follows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         tgt_reg   <= '0;
         retry_reg <= '0;
         j_reg     <= '0;
         k_reg     <= '0;
      end else begin
         state_reg <= state_next;
         tgt_reg   <= tgt_next;
         retry_reg <= retry_next;
         j_reg     <= j_next;
         k_reg     <= k_next;
      end
   end

   // Next-state logic. j/k default to zero, so they are non-zero only in
   // the single cycle spent in DRIVE.
   always_comb begin
      state_next = state_reg;
      tgt_next   = tgt_reg;
      retry_next = retry_reg;
      j_next     = '0;
      k_next     = '0;

      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               tgt_next   = bus.target;
               retry_next = '0;
               j_next     = j_exc;
               k_next     = k_exc;
               state_next = ST_DRIVE;
            end
         end

         ST_DRIVE: begin
            // The bank samples j/k on the edge that ends this cycle.
            state_next = ST_CHECK;
         end

         ST_CHECK: begin
            if (bus.q_fb == tgt_reg) begin
               state_next = ST_DONE;
            end else if (retry_reg < RETRY_LIMIT) begin
               retry_next = retry_reg + 4'd1;
               j_next     = j_exc;
               k_next     = k_exc;
               state_next = ST_DRIVE;
            end else begin
               state_next = ST_ERR;
            end
         end

         ST_DONE: state_next = ST_IDLE;

         ST_ERR: state_next = ST_IDLE;

         default: state_next = ST_IDLE;
      endcase
   end

   // Status outputs are decoded straight from the state register. This
   // keeps them glitch-free, and they drop as soon as reset is asserted.
   assign bus.j    = j_reg;
   assign bus.k    = k_reg;
   assign bus.busy = (state_reg != ST_IDLE);
   assign bus.done = (state_reg == ST_DONE);
   assign bus.err  = (state_reg == ST_ERR);

endmodule

// File: tb/tb_jk_load_ctrl.sv
module tb_jk_load_ctrl;

   localparam int W  = 4;
   localparam int MR = 2;

   logic clk;
   logic rst;

   jk_load_ctrl_if #(.WIDTH(W)) bus ();

   jk_load_ctrl #(
      .WIDTH(W),
      .MAX_RETRY(MR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural jkff bank. It can be preloaded, or frozen to model stuck bits.
   logic [W-1:0] q_bank;
   logic         load_en;
   logic [W-1:0] load_val;
   logic         stuck;

   always @(posedge clk) begin
      if (load_en) begin
         q_bank <= load_val;
      end else if (!stuck) begin
         for (int b = 0; b < W; b++) begin
            case ({bus.j[b], bus.k[b]})
               2'b10:   q_bank[b] <= 1'b1;
               2'b01:   q_bank[b] <= 1'b0;
               2'b11:   q_bank[b] <= ~q_bank[b];
               default: q_bank[b] <= q_bank[b];
            endcase
         end
      end
   end

   assign bus.q_fb = q_bank;

   typedef struct {
      logic [W-1:0] q_init;
      logic [W-1:0] tgt;
      bit           stk;
      logic [W-1:0] exp_j;   // set/reset build expectation
      logic [W-1:0] exp_k;
      bit           exp_err;
      int           exp_lat;
      int           exp_drives;
      logic [W-1:0] exp_q;
   } vec_t;

   vec_t vecs[6];
   vec_t sb_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic preload(input logic [W-1:0] val, input bit stk);
      @(negedge clk);
      stuck    = stk;
      load_en  = 1'b1;
      load_val = val;
      @(negedge clk);
      load_en  = 1'b0;
   endtask

   // Runs one load transaction.
   // - The expected result is pushed to the scoreboard as the stimulus is
   //   driven.
   // - It is popped and compared when done or err appears.
   task automatic run_vec(input int idx, input vec_t v);
      logic [W-1:0] ej;
      logic [W-1:0] ek;
      vec_t         e;
      int           drives;
      int           busy_cnt;
      bit           finished;
      preload(v.q_init, v.stk);
`ifdef JK_LOAD_TOGGLE_EN
      ej = v.tgt ^ v.q_init;
      ek = v.tgt ^ v.q_init;
`else
      ej = v.exp_j;
      ek = v.exp_k;
`endif
      sb_q.push_back(v);
      bus.start  = 1'b1;
      bus.target = v.tgt;
      @(negedge clk);
      bus.start = 1'b0;
      drives   = 0;
      busy_cnt = 0;
      finished = 1'b0;
      for (int cyc = 1; cyc <= 20 && !finished; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (cyc == 1) begin
            check("drive_j", 32'(bus.j), 32'(ej));
            check("drive_k", 32'(bus.k), 32'(ek));
         end
`ifndef JK_LOAD_TOGGLE_EN
         check("jk_exclusive", 32'(bus.j & bus.k), 32'd0);
`endif
         if (bus.j != '0 || bus.k != '0) begin
            drives++;
            check("pulse_j", 32'(bus.j), 32'(ej));
         end
         if (bus.busy) busy_cnt++;
         if (bus.done || bus.err) begin
            finished = 1'b1;
            if (sb_q.size() == 0) begin
               check("sb_nonempty", 32'd0, 32'd1);
            end else begin
               e = sb_q.pop_front();
               check("outcome_err", 32'(bus.err), 32'(e.exp_err));
               check("outcome_done", 32'(bus.done), 32'(!e.exp_err));
               check("latency", 32'(cyc), 32'(e.exp_lat));
               check("drive_pulses", 32'(drives), 32'(e.exp_drives));
               check("busy_cycles", 32'(busy_cnt), 32'(e.exp_lat));
               check("bank_q", 32'(q_bank), 32'(e.exp_q));
            end
         end
      end
      if (!finished) check("timeout", 32'd0, 32'd1);
      @(negedge clk);
      check("post_idle", 32'({bus.busy, bus.done, bus.err}), 32'd0);
      $display("txn %0d q0=%b tgt=%b stuck=%0d drives=%0d busy=%0d q=%b",
               idx, v.q_init, v.tgt, v.stk, drives, busy_cnt, q_bank);
      stuck = 1'b0;
   endtask

   // Counts done/err pulses over n cycles.
   task automatic count_pulses(input int n, output int n_done, output int n_err);
      n_done = 0;
      n_err  = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (bus.done) n_done++;
         if (bus.err)  n_err++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd;
      int ne;

      vecs[0] = '{4'b0000, 4'b1010, 1'b0, 4'b1010, 4'b0000, 1'b0, 3, 1, 4'b1010};
      vecs[1] = '{4'b1100, 4'b0110, 1'b0, 4'b0010, 4'b1000, 1'b0, 3, 1, 4'b0110};
      vecs[2] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b0, 3, 0, 4'b0101};
      vecs[3] = '{4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 7, 3, 4'b0000};
      vecs[4] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 3, 1, 4'b0000};
      vecs[5] = '{4'b0011, 4'b1100, 1'b0, 4'b1100, 4'b0011, 1'b0, 3, 1, 4'b1100};

      // Reset held with start high: all outputs stay low.
      rst        = 1'b0;
      bus.start  = 1'b1;
      bus.target = 4'b1111;
      load_en    = 1'b1;
      load_val   = 4'b0000;
      stuck      = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("reset_outputs", 32'({bus.j, bus.k, bus.busy, bus.done, bus.err}), 32'd0);
      end
      bus.start = 1'b0;
      load_en   = 1'b0;
      rst       = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("idle_after_reset", 32'({bus.busy, bus.j, bus.k}), 32'd0);
      end

      // Table-driven loads.
      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // A start asserted while busy is ignored: one done only, original target.
      preload(4'b0000, 1'b0);
      bus.start  = 1'b1;
      bus.target = 4'b1010;
      @(negedge clk);               // cycle 1 (DRIVE)
      bus.target = 4'b0101;         // start stays high, with a new word
      @(negedge clk);               // cycle 2 (CHECK)
      @(negedge clk);               // cycle 3 (DONE)
      check("ignore_done_pulse", 32'(bus.done), 32'd1);
      bus.start = 1'b0;
      count_pulses(8, nd, ne);
      check("ignore_extra_done", 32'(nd), 32'd0);
      check("ignore_err", 32'(ne), 32'd0);
      check("ignore_bank_q", 32'(q_bank), 32'(4'b1010));
      $display("txn ignore-start q=%b extra_done=%0d", q_bank, nd);

      // Reset asserted during CHECK aborts with no done/err afterwards.
      preload(4'b0000, 1'b0);
      bus.start  = 1'b1;
      bus.target = 4'b0110;
      @(negedge clk);               // DRIVE
      bus.start = 1'b0;
      check("abort_busy_before", 32'(bus.busy), 32'd1);
      @(negedge clk);               // CHECK
      rst = 1'b0;
      #1;
      check("abort_outputs", 32'({bus.j, bus.k, bus.busy, bus.done, bus.err}), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      count_pulses(6, nd, ne);
      check("abort_no_done", 32'(nd), 32'd0);
      check("abort_no_err", 32'(ne), 32'd0);
      check("abort_idle", 32'(bus.busy), 32'd0);
      $display("txn abort-in-check done=%0d err=%0d", nd, ne);

      // A normal load works after the abort.
      run_vec(99, vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
